// File: rtl/if_id_skid_reg_pkg.sv
// Shared constants and occupancy encoding for the IF/ID skid register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_id_skid_reg_pkg;

   localparam int          ADDRWIDTH    = 32;
   localparam logic [31:0] NOP_INST_DEF = 32'hF8000000;

   // Occupancy of the out/skid slot pair.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,   // nothing held
      OCC_ONE   = 2'b01,   // out slot valid
      OCC_FULL  = 2'b11    // out slot and skid slot valid
   } occ_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Valid/ready beat bus carrying {pc, instruction} between pipeline stages.
// Latency: none (wires only).
// Backpressure: producer holds valid/pc/instruction until ready is seen high.
interface if_id_skid_reg_if
   import if_id_skid_reg_pkg::*;
#(
   parameter int NB_PC   = ADDRWIDTH,
   parameter int NB_INST = 32
) ();

   logic               valid;
   logic               ready;
   logic [NB_PC-1:0]   pc;
   logic [NB_INST-1:0] instruction;

   modport master (output valid, output pc, output instruction, input ready);
   modport slave  (input valid, input pc, input instruction, output ready);

endinterface

// File: rtl/if_id_skid_reg_slot.sv
// One {valid, pc, instruction} holding register with load and clear.
// Latency: load visible one cycle after the loading edge.
// Backpressure: none; the owner decides when to load or clear.
module if_id_skid_reg_slot #(
   parameter int                 NB_PC    = 32,
   parameter int                 NB_INST  = 32,
   parameter logic [NB_INST-1:0] RST_INST = '0
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic [NB_PC-1:0]   pc_i,
   input  logic [NB_INST-1:0] inst_i,
   output logic               valid_o,
   output logic [NB_PC-1:0]   pc_o,
   output logic [NB_INST-1:0] inst_o
);

   logic               valid_q;
   logic [NB_PC-1:0]   pc_q;
   logic [NB_INST-1:0] inst_q;

   // Load wins over clear; clear only drops valid so the payload stays visible.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= RST_INST;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         inst_q  <= inst_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with 2-entry skid, flush-to-NOP and debug freeze (stats: IF_ID_STATS_EN).
// Latency: beat accepted at edge N is presented to ID in cycle N+1.
// Backpressure: ready is registered occupancy (drops only when both slots full), gated by enable.
module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int                 NB_INST  = 32,
   parameter int                 NB_PC    = ADDRWIDTH,
   parameter logic [NB_INST-1:0] NOP_INST = NB_INST'(NOP_INST_DEF),
   parameter int                 NB_CNT   = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               enable_i,
   input  logic               flush_i,
   if_id_skid_reg_if.slave    fetch_if,
   if_id_skid_reg_if.master   decode_if,
   output logic [NB_CNT-1:0]  stall_cnt_o,
   output logic [NB_CNT-1:0]  flush_cnt_o
);

   occ_e               state_q, state_d;
   logic               ready;
   logic               xfer_in, xfer_out;
   logic               load_out, clr_out, load_skid, clr_skid;
   logic               out_vld, skid_vld;
   logic [NB_PC-1:0]   out_pc, skid_pc, out_pc_src;
   logic [NB_INST-1:0] out_inst, skid_inst, out_inst_src;

   // Ready comes from registered occupancy only; ID's ready never reaches it.
   assign ready    = enable_i & (state_q != OCC_FULL);
   assign xfer_in  = fetch_if.valid & ready;
   assign xfer_out = out_vld & decode_if.ready & enable_i;

   // Whenever the skid holds a beat, it is the only legal source for the out
   // slot, which keeps older beats ahead of newer ones.
   assign out_pc_src   = skid_vld ? skid_pc   : fetch_if.pc;
   assign out_inst_src = skid_vld ? skid_inst : fetch_if.instruction;

   // Occupancy state register.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= OCC_EMPTY;
      else         state_q <= state_d;
   end

   // Next occupancy and slot load/clear strobes; freeze leaves everything as is.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      clr_out   = 1'b0;
      load_skid = 1'b0;
      clr_skid  = 1'b0;
      if (enable_i) begin
         if (flush_i) begin
            state_d  = OCC_EMPTY;
            clr_out  = 1'b1;
            clr_skid = 1'b1;
         end else begin
            case (state_q)
               OCC_EMPTY: begin
                  if (xfer_in) begin
                     load_out = 1'b1;
                     state_d  = OCC_ONE;
                  end
               end
               OCC_ONE: begin
                  if (xfer_in && !xfer_out) begin
                     load_skid = 1'b1;
                     state_d   = OCC_FULL;
                  end else if (xfer_in && xfer_out) begin
                     load_out = 1'b1;
                  end else if (xfer_out) begin
                     clr_out = 1'b1;
                     state_d = OCC_EMPTY;
                  end
               end
               OCC_FULL: begin
                  if (xfer_out) begin
                     load_out = 1'b1;
                     clr_skid = 1'b1;
                     state_d  = OCC_ONE;
                  end
               end
               default: state_d = OCC_EMPTY;
            endcase
         end
      end
   end

   if_id_skid_reg_slot #(
      .NB_PC(NB_PC), .NB_INST(NB_INST), .RST_INST(NOP_INST)
   ) u_out_slot (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (load_out),
      .clear_i (clr_out),
      .pc_i    (out_pc_src),
      .inst_i  (out_inst_src),
      .valid_o (out_vld),
      .pc_o    (out_pc),
      .inst_o  (out_inst)
   );

   if_id_skid_reg_slot #(
      .NB_PC(NB_PC), .NB_INST(NB_INST), .RST_INST(NOP_INST)
   ) u_skid_slot (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (load_skid),
      .clear_i (clr_skid),
      .pc_i    (fetch_if.pc),
      .inst_i  (fetch_if.instruction),
      .valid_o (skid_vld),
      .pc_o    (skid_pc),
      .inst_o  (skid_inst)
   );

   assign fetch_if.ready        = ready;
   assign decode_if.valid       = out_vld;
   assign decode_if.pc          = out_pc;
   assign decode_if.instruction = out_vld ? out_inst : NOP_INST;

`ifdef IF_ID_STATS_EN
   logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;
   logic [NB_CNT-1:0] flush_cnt_q, flush_cnt_d;
   logic [2:0]        n_disc;
   logic [NB_CNT:0]   flush_sum;

   // Saturating counters: stalled presentation cycles and beats lost to flush.
   // A beat consumed by ID in the flush cycle is not lost; a beat accepted
   // from IF in the flush cycle is.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      n_disc      = {2'b0, out_vld} + {2'b0, skid_vld} + {2'b0, xfer_in}
                    - {2'b0, xfer_out};
      flush_sum   = {1'b0, flush_cnt_q} + (NB_CNT+1)'(n_disc);
      if (enable_i && out_vld && !decode_if.ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (enable_i && flush_i)
         flush_cnt_d = flush_sum[NB_CNT] ? '1 : flush_sum[NB_CNT-1:0];
   end

   // Counter registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: ready_i driven directly by the bench, randomly in the random phase.
module tb_if_id_skid_reg;
   import if_id_skid_reg_pkg::*;

   localparam int          NBC  = 4;
   localparam int          CMAX = 15;
   localparam logic [31:0] NOP  = 32'hF8000000;
`ifdef IF_ID_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, en, fl;
   logic [NBC-1:0] stall_cnt, flush_cnt;

   if_id_skid_reg_if #(.NB_PC(32), .NB_INST(32)) fetch_bus ();
   if_id_skid_reg_if #(.NB_PC(32), .NB_INST(32)) decode_bus ();

   if_id_skid_reg #(
      .NB_INST(32), .NB_PC(32), .NOP_INST(32'hF8000000), .NB_CNT(NBC)
   ) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .enable_i    (en),
      .flush_i     (fl),
      .fetch_if    (fetch_bus),
      .decode_if   (decode_bus),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } beat_t;

   beat_t       mq[$];
   logic [31:0] m_last_pc;
   int          m_stall, m_flush;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] ins_tab [4];

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   function automatic logic m_valid();
      return mq.size() > 0;
   endfunction
   function automatic logic [31:0] m_pc();
      return (mq.size() > 0) ? mq[0].pc : m_last_pc;
   endfunction
   function automatic logic [31:0] m_ins();
      return (mq.size() > 0) ? mq[0].ins : NOP;
   endfunction
   function automatic logic m_ready();
      return en && (mq.size() < 2);
   endfunction
   function automatic logic [NBC-1:0] m_stall_exp();
      return STATS ? NBC'(m_stall) : '0;
   endfunction
   function automatic logic [NBC-1:0] m_flush_exp();
      return STATS ? NBC'(m_flush) : '0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_last_pc = '0;
      m_stall   = 0;
      m_flush   = 0;
   endtask

   // Drive one cycle of inputs, clock it, and advance the model by the
   // queue-level rules: a two-deep FIFO, flush empties it.
   task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic f, input logic e);
      int    held;
      bit    inx, outx;
      beat_t b, gone;
      fetch_bus.valid       = v;
      fetch_bus.pc          = pc;
      fetch_bus.instruction = ins;
      decode_bus.ready      = rdy;
      fl = f;
      en = e;
      held = mq.size();
      inx  = v && e && (held < 2);
      outx = e && rdy && (held > 0);
      b.pc  = pc;
      b.ins = ins;
      @(posedge clk);
      #1;
      if (e) begin
         if (held > 0 && !rdy) m_stall = sat(m_stall + 1);
         if (f) begin
            m_flush = sat(m_flush + held - int'(outx) + int'(inx));
            mq.delete();
         end else begin
            if (outx) gone = mq.pop_front();
            if (inx) mq.push_back(b);
         end
         if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; fl = 1'b0;
      fetch_bus.valid = 1'b0; fetch_bus.pc = '0; fetch_bus.instruction = '0;
      decode_bus.ready = 1'b0;
      #12;
      checks++; if (decode_bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", decode_bus.valid); end
      checks++; if (fetch_bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", fetch_bus.ready); end
      checks++; if (decode_bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", decode_bus.pc); end
      checks++; if (decode_bus.instruction !== NOP) begin errors++; $display("FAIL rst_inst got=%h exp=%h", decode_bus.instruction, NOP); end
      checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_pass_through();
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 32'(k + 1), ins_tab[k], 1'b1, 1'b0, 1'b1);
         checks++; if (decode_bus.valid !== 1'b1 || decode_bus.pc !== 32'(k + 1) || decode_bus.instruction !== ins_tab[k])
            begin errors++; $display("FAIL pass_beat%0d got=%b/%h/%h exp=1/%h/%h", k, decode_bus.valid, decode_bus.pc, decode_bus.instruction, k + 1, ins_tab[k]); end
         checks++; if (fetch_bus.ready !== 1'b1) begin errors++; $display("FAIL pass_ready%0d got=%b exp=1", k, fetch_bus.ready); end
      end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      checks++; if (decode_bus.valid !== 1'b0 || decode_bus.instruction !== NOP || decode_bus.pc !== 32'd4)
         begin errors++; $display("FAIL pass_drain got=%b/%h/%h exp=0/%h/4", decode_bus.valid, decode_bus.instruction, decode_bus.pc, NOP); end
   endtask

   task automatic test_backpressure();
      logic [31:0] seen [3];
      cyc(1'b1, 32'd1, ins_tab[0], 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'd2, ins_tab[1], 1'b0, 1'b0, 1'b1);
      checks++; if (decode_bus.pc !== 32'd1 || fetch_bus.ready !== 1'b0)
         begin errors++; $display("FAIL bp_full got=pc%h rdy%b exp=pc1 rdy0", decode_bus.pc, fetch_bus.ready); end
      cyc(1'b1, 32'd3, ins_tab[2], 1'b0, 1'b0, 1'b1);
      checks++; if (decode_bus.pc !== 32'd1 || fetch_bus.ready !== 1'b0 || decode_bus.valid !== 1'b1)
         begin errors++; $display("FAIL bp_hold got=pc%h rdy%b v%b exp=pc1 rdy0 v1", decode_bus.pc, fetch_bus.ready, decode_bus.valid); end
      // pc1 leaves on this edge; pc3 still waits because ready was low.
      cyc(1'b1, 32'd3, ins_tab[2], 1'b1, 1'b0, 1'b1);
      seen[0] = decode_bus.pc;
      cyc(1'b1, 32'd3, ins_tab[2], 1'b1, 1'b0, 1'b1);
      seen[1] = decode_bus.pc;
      checks++; if (seen[0] !== 32'd2 || seen[1] !== 32'd3)
         begin errors++; $display("FAIL bp_order got=%h,%h exp=2,3", seen[0], seen[1]); end
      checks++; if (fetch_bus.ready !== 1'b1 || decode_bus.instruction !== ins_tab[2])
         begin errors++; $display("FAIL bp_resume got=rdy%b ins%h exp=rdy1 ins%h", fetch_bus.ready, decode_bus.instruction, ins_tab[2]); end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      seen[2] = {31'b0, decode_bus.valid};
      checks++; if (seen[2] !== 32'd0) begin errors++; $display("FAIL bp_empty got=%h exp=0", seen[2]); end
   endtask

   task automatic test_flush_full();
      int f0;
      cyc(1'b1, 32'd6, 32'h11111111, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'd7, 32'h22222222, 1'b0, 1'b0, 1'b1);
      f0 = int'(flush_cnt);
      checks++; if (fetch_bus.ready !== 1'b0) begin errors++; $display("FAIL ff_full got=%b exp=0", fetch_bus.ready); end
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      checks++; if (decode_bus.valid !== 1'b0 || decode_bus.instruction !== 32'hF8000000 || fetch_bus.ready !== 1'b1)
         begin errors++; $display("FAIL ff_out got=v%b ins%h rdy%b exp=v0 insf8000000 rdy1", decode_bus.valid, decode_bus.instruction, fetch_bus.ready); end
      checks++; if (decode_bus.pc !== 32'd6) begin errors++; $display("FAIL ff_pc got=%h exp=6", decode_bus.pc); end
      checks++; if (flush_cnt !== (STATS ? NBC'(sat(f0 + 2)) : NBC'(0)))
         begin errors++; $display("FAIL ff_cnt got=%0d exp=%0d", flush_cnt, STATS ? sat(f0 + 2) : 0); end
   endtask

   task automatic test_flush_concurrent();
      int f0;
      cyc(1'b1, 32'd4, ins_tab[3], 1'b0, 1'b0, 1'b1);
      f0 = int'(flush_cnt);
      cyc(1'b1, 32'd5, 32'h33333333, 1'b1, 1'b1, 1'b1);
      checks++; if (decode_bus.valid !== 1'b0) begin errors++; $display("FAIL fc_valid got=%b exp=0", decode_bus.valid); end
      checks++; if (flush_cnt !== (STATS ? NBC'(sat(f0 + 1)) : NBC'(0)))
         begin errors++; $display("FAIL fc_cnt got=%0d exp=%0d", flush_cnt, STATS ? sat(f0 + 1) : 0); end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      checks++; if (decode_bus.valid !== 1'b0 || decode_bus.pc !== 32'd4)
         begin errors++; $display("FAIL fc_nopc5 got=v%b pc%h exp=v0 pc4", decode_bus.valid, decode_bus.pc); end
   endtask

   task automatic test_freeze();
      logic [NBC-1:0] s0, f0;
      cyc(1'b1, 32'd8, 32'h44444444, 1'b0, 1'b0, 1'b1);
      s0 = stall_cnt;
      f0 = flush_cnt;
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 32'd9, 32'h55555555, 1'b1, 1'b1, 1'b0);
         checks++; if (decode_bus.valid !== 1'b1 || decode_bus.pc !== 32'd8 || decode_bus.instruction !== 32'h44444444)
            begin errors++; $display("FAIL frz_out%0d got=v%b pc%h ins%h exp=v1 pc8 ins44444444", k, decode_bus.valid, decode_bus.pc, decode_bus.instruction); end
         checks++; if (fetch_bus.ready !== 1'b0) begin errors++; $display("FAIL frz_ready%0d got=%b exp=0", k, fetch_bus.ready); end
         checks++; if (stall_cnt !== s0 || flush_cnt !== f0)
            begin errors++; $display("FAIL frz_cnt%0d got=%0d/%0d exp=%0d/%0d", k, stall_cnt, flush_cnt, s0, f0); end
      end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      checks++; if (decode_bus.valid !== 1'b0) begin errors++; $display("FAIL frz_resume got=%b exp=0", decode_bus.valid); end
   endtask

   task automatic test_stall_sat();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      model_reset();
      cyc(1'b1, 32'd10, 32'h66666666, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
         if (k == 9) begin
            checks++; if (stall_cnt !== (STATS ? NBC'(10) : NBC'(0)))
               begin errors++; $display("FAIL stall_mid got=%0d exp=%0d", stall_cnt, STATS ? 10 : 0); end
         end
      end
      checks++; if (stall_cnt !== (STATS ? NBC'(15) : NBC'(0)) || decode_bus.valid !== 1'b1)
         begin errors++; $display("FAIL stall_sat got=%0d v%b exp=%0d v1", stall_cnt, decode_bus.valid, STATS ? 15 : 0); end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 32'd12, 32'h77777777, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'd13, 32'h88888888, 1'b0, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (decode_bus.valid !== 1'b0 || decode_bus.pc !== 32'h0 || decode_bus.instruction !== NOP || fetch_bus.ready !== 1'b1)
         begin errors++; $display("FAIL rmid got=v%b pc%h ins%h rdy%b exp=v0 pc0 ins%h rdy1", decode_bus.valid, decode_bus.pc, decode_bus.instruction, fetch_bus.ready, NOP); end
      checks++; if (stall_cnt !== '0 || flush_cnt !== '0)
         begin errors++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic        v, r, f, e;
      logic [31:0] pc, ins;
      for (int k = 0; k < 400; k++) begin
         v   = 1'($urandom_range(0, 3) != 0);
         r   = 1'($urandom_range(0, 2) != 0);
         f   = 1'($urandom_range(0, 15) == 0);
         e   = 1'($urandom_range(0, 7) != 0);
         pc  = $urandom;
         ins = $urandom;
         cyc(v, pc, ins, r, f, e);
         checks++; if (decode_bus.valid !== m_valid())
            begin errors++; $display("FAIL rnd_valid@%0d got=%b exp=%b", k, decode_bus.valid, m_valid()); end
         checks++; if (decode_bus.pc !== m_pc())
            begin errors++; $display("FAIL rnd_pc@%0d got=%h exp=%h", k, decode_bus.pc, m_pc()); end
         checks++; if (decode_bus.instruction !== m_ins())
            begin errors++; $display("FAIL rnd_inst@%0d got=%h exp=%h", k, decode_bus.instruction, m_ins()); end
         checks++; if (fetch_bus.ready !== m_ready())
            begin errors++; $display("FAIL rnd_ready@%0d got=%b exp=%b", k, fetch_bus.ready, m_ready()); end
         checks++; if (stall_cnt !== m_stall_exp())
            begin errors++; $display("FAIL rnd_stall@%0d got=%0d exp=%0d", k, stall_cnt, m_stall_exp()); end
         checks++; if (flush_cnt !== m_flush_exp())
            begin errors++; $display("FAIL rnd_flush@%0d got=%0d exp=%0d", k, flush_cnt, m_flush_exp()); end
      end
   endtask

   initial begin
      ins_tab[0] = 32'h8c080000;
      ins_tab[1] = 32'h8c090004;
      ins_tab[2] = 32'h2911000f;
      ins_tab[3] = 32'hfc000000;
      test_reset();
      test_pass_through();
      test_backpressure();
      test_flush_full();
      test_flush_concurrent();
      test_freeze();
      test_stall_sat();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
